// File: rtl/cpu_sequencer_if.sv
// Handshake bundle between the CPU v0.1 sequencer and the rest of the
// datapath: run/step control, the decode flags coming back from the
// control unit, the datapath strobes and the debug-display outputs.
interface cpu_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             run;
  logic             step;
  logic             clr_halt;
  logic             dec_reg_write;
  logic             dec_halt;
  logic             ir_load;
  logic             ula_en;
  logic             rf_we;
  logic             pc_en;
  logic             busy;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  // Master side: whoever drives run/step and supplies the decode flags
  modport master (
    output run, step, clr_halt, dec_reg_write, dec_halt,
    input  ir_load, ula_en, rf_we, pc_en, busy, halted, state, instr_count
  );

  // Slave side: the sequencer itself
  modport slave (
    input  run, step, clr_halt, dec_reg_write, dec_halt,
    output ir_load, ula_en, rf_we, pc_en, busy, halted, state, instr_count
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multicycle control sequencer for CPU v0.1.
// Walks each instruction through FETCH, DECODE, EXEC and WB, either one
// instruction per debounced step-key edge or back-to-back while run is
// high, with optional idle cycles between instructions in run mode.
// A halt instruction parks the sequencer in HALT until clr_halt.
// State and a retired-instruction count are exported for the debug displays.
module cpu_sequencer #(
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 8
) (
  input logic            clk,
  input logic            rst,
  cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_WAIT   = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  // WAIT is only ever entered when WAIT_CYCLES > 0, so the reload value is
  // guarded to keep the constant in range when the wait phase is disabled.
  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [7:0] WAIT_LOAD = HAS_WAIT ? 8'(WAIT_CYCLES - 1) : 8'd0;

  state_t           r_state;
  logic             r_stepQ;
  logic             r_rwL;
  logic             r_hL;
  logic [7:0]       r_waitCnt;
  logic [CNT_W-1:0] r_count;
  logic             r_irLoad;
  logic             r_ulaEn;
  logic             r_rfWe;
  logic             r_pcEn;
  logic             r_busy;
  logic             r_halted;

  logic             w_stepRise;
  state_t           w_nextState;

  assign w_stepRise = bus.step & ~r_stepQ;

  // Next-state decision; the unused code 6 falls into the default and recovers to IDLE
  always_comb begin
    w_nextState = S_IDLE;
    case (r_state)
      S_IDLE:   w_nextState = (bus.run || w_stepRise) ? S_FETCH : S_IDLE;
      S_FETCH:  w_nextState = S_DECODE;
      S_DECODE: w_nextState = S_EXEC;
      S_EXEC:   w_nextState = S_WB;
      S_WB: begin
        if (r_hL)                      w_nextState = S_HALT;
        else if (bus.run && HAS_WAIT)  w_nextState = S_WAIT;
        else if (bus.run)              w_nextState = S_FETCH;
        else                           w_nextState = S_IDLE;
      end
      S_WAIT: begin
        if (!bus.run)                  w_nextState = S_IDLE;
        else if (r_waitCnt == 8'd0)    w_nextState = S_FETCH;
        else                           w_nextState = S_WAIT;
      end
      S_HALT:   w_nextState = bus.clr_halt ? S_IDLE : S_HALT;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Sequencer register bank: state, decode latches, wait counter, retire counter and strobes registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_stepQ   <= 1'b0;
      r_rwL     <= 1'b0;
      r_hL      <= 1'b0;
      r_waitCnt <= 8'd0;
      r_count   <= '0;
      r_irLoad  <= 1'b0;
      r_ulaEn   <= 1'b0;
      r_rfWe    <= 1'b0;
      r_pcEn    <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_stepQ <= bus.step;
      r_state <= w_nextState;

      if (r_state == S_DECODE) begin
        r_rwL <= bus.dec_reg_write;
        r_hL  <= bus.dec_halt;
      end

      if (w_nextState == S_WAIT) begin
        r_waitCnt <= (r_state == S_WAIT) ? r_waitCnt - 8'd1 : WAIT_LOAD;
      end

      if (r_state == S_WB) begin
        r_count <= r_count + CNT_W'(1);
      end

      r_irLoad <= (w_nextState == S_FETCH);
      r_ulaEn  <= (w_nextState == S_EXEC);
      r_rfWe   <= (w_nextState == S_WB) && r_rwL && !r_hL;
      r_pcEn   <= (w_nextState == S_WB) && !r_hL;
      r_busy   <= (w_nextState == S_FETCH) || (w_nextState == S_DECODE) ||
                  (w_nextState == S_EXEC)  || (w_nextState == S_WB)     ||
                  (w_nextState == S_WAIT);
      r_halted <= (w_nextState == S_HALT);
    end
  end

  assign bus.state       = r_state;
  assign bus.instr_count = r_count;
  assign bus.ir_load     = r_irLoad;
  assign bus.ula_en      = r_ulaEn;
  assign bus.rf_we       = r_rfWe;
  assign bus.pc_en       = r_pcEn;
  assign bus.busy        = r_busy;
  assign bus.halted      = r_halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: two instances (no wait cycles, and three wait
// cycles) run side by side against a per-instance behavioural model that
// tracks "position within the current instruction" rather than a state code.
module tb_cpu_sequencer;

  localparam int NI = 2;

  logic clk;
  logic rst;

  logic [1:0] runIn, stepIn, clrIn, drIn, dhIn;

  logic [2:0] obsState [NI];
  logic [7:0] obsCount [NI];
  logic [1:0] obsBusy, obsHalted, obsIr, obsUla, obsRf, obsPc;

  cpu_sequencer_if #(.CNT_W(8)) if0 ();
  cpu_sequencer_if #(.CNT_W(8)) if1 ();

  cpu_sequencer #(.WAIT_CYCLES(0), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  cpu_sequencer #(.WAIT_CYCLES(3), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if0.run = runIn[0];  assign if0.step = stepIn[0];  assign if0.clr_halt = clrIn[0];
  assign if0.dec_reg_write = drIn[0];  assign if0.dec_halt = dhIn[0];
  assign if1.run = runIn[1];  assign if1.step = stepIn[1];  assign if1.clr_halt = clrIn[1];
  assign if1.dec_reg_write = drIn[1];  assign if1.dec_halt = dhIn[1];

  assign obsState[0] = if0.state;        assign obsState[1] = if1.state;
  assign obsCount[0] = if0.instr_count;  assign obsCount[1] = if1.instr_count;
  assign obsBusy   = {if1.busy,    if0.busy};
  assign obsHalted = {if1.halted,  if0.halted};
  assign obsIr     = {if1.ir_load, if0.ir_load};
  assign obsUla    = {if1.ula_en,  if0.ula_en};
  assign obsRf     = {if1.rf_we,   if0.rf_we};
  assign obsPc     = {if1.pc_en,   if0.pc_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecCount = 0;
  int missCount = 0;

  // Reference model: an instruction is a run of cycles numbered from 0
  // (0..3 = fetch/decode/exec/writeback, 4.. = idle gap in run mode).
  int waitN [NI] = '{0, 3};
  bit mIdle [NI];
  bit mHalt [NI];
  int mPos [NI];
  bit mRw [NI];
  bit mH [NI];
  bit mStepQ [NI];
  int mCount [NI];

  int tallyIr [NI];
  int tallyUla [NI];
  int tallyRf [NI];
  int tallyPc [NI];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int modelState(int i);
    if (mHalt[i]) return 7;
    if (mIdle[i]) return 0;
    if (mPos[i] < 4) return mPos[i] + 1;
    return 5;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NI; i++) begin
      mIdle[i] = 1'b1; mHalt[i] = 1'b0; mPos[i] = 0;
      mRw[i] = 1'b0; mH[i] = 1'b0; mStepQ[i] = 1'b0; mCount[i] = 0;
    end
  endtask

  task automatic modelEdge();
    for (int i = 0; i < NI; i++) begin
      bit rise;
      rise = stepIn[i] & ~mStepQ[i];
      mStepQ[i] = stepIn[i];
      if (mHalt[i]) begin
        if (clrIn[i]) begin mHalt[i] = 1'b0; mIdle[i] = 1'b1; end
      end else if (mIdle[i]) begin
        if (runIn[i] || rise) begin mIdle[i] = 1'b0; mPos[i] = 0; end
      end else if (mPos[i] < 3) begin
        if (mPos[i] == 1) begin mRw[i] = drIn[i]; mH[i] = dhIn[i]; end
        mPos[i]++;
      end else if (mPos[i] == 3) begin
        mCount[i] = (mCount[i] + 1) % 256;
        if (mH[i])                         mHalt[i] = 1'b1;
        else if (runIn[i] && waitN[i] > 0) mPos[i] = 4;
        else if (runIn[i])                 mPos[i] = 0;
        else                               mIdle[i] = 1'b1;
      end else begin
        if (!runIn[i])                     mIdle[i] = 1'b1;
        else if (mPos[i] == 3 + waitN[i])  mPos[i] = 0;
        else                               mPos[i]++;
      end
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < NI; i++) begin
      bit active;
      active = !mIdle[i] && !mHalt[i];
      checkOutput($sformatf("state%0d", i),  32'(obsState[i]),  32'(modelState(i)));
      checkOutput($sformatf("busy%0d", i),   32'(obsBusy[i]),   32'(active));
      checkOutput($sformatf("halted%0d", i), 32'(obsHalted[i]), 32'(mHalt[i]));
      checkOutput($sformatf("irLoad%0d", i), 32'(obsIr[i]),     32'(active && mPos[i] == 0));
      checkOutput($sformatf("ulaEn%0d", i),  32'(obsUla[i]),    32'(active && mPos[i] == 2));
      checkOutput($sformatf("rfWe%0d", i),   32'(obsRf[i]),     32'(active && mPos[i] == 3 && mRw[i] && !mH[i]));
      checkOutput($sformatf("pcEn%0d", i),   32'(obsPc[i]),     32'(active && mPos[i] == 3 && !mH[i]));
      checkOutput($sformatf("count%0d", i),  32'(obsCount[i]),  32'(mCount[i]));
    end
  endtask

  task automatic clearTally();
    for (int i = 0; i < NI; i++) begin
      tallyIr[i] = 0; tallyUla[i] = 0; tallyRf[i] = 0; tallyPc[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
    for (int i = 0; i < NI; i++) begin
      if (obsIr[i])  tallyIr[i]++;
      if (obsUla[i]) tallyUla[i]++;
      if (obsRf[i])  tallyRf[i]++;
      if (obsPc[i])  tallyPc[i]++;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] run, input logic [1:0] step,
                               input logic [1:0] clr, input logic [1:0] dr, input logic [1:0] dh);
    runIn = run; stepIn = step; clrIn = clr; drIn = dr; dhIn = dh;
  endtask

  // Asserts reset between edges so its asynchronous effect is visible at once
  task automatic applyReset();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    repeat (3) begin
      @(posedge clk);
      #1;
      checkAll();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    modelReset();
    @(posedge clk);
    #1;

    // Reset and idle hold
    applyReset();
    repeat (10) tick();
    checkOutput("idleHold0", 32'(obsState[0]), 32'd0);
    checkOutput("idleHold1", 32'(obsState[1]), 32'd0);

    // Single step with a held-high key
    clearTally();
    applyStimulus(2'b00, 2'b11, 2'b00, 2'b11, 2'b00);
    repeat (6) tick();
    stepIn = 2'b00;
    repeat (6) tick();
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("stepIr%0d", i),    32'(tallyIr[i]),     32'd1);
      checkOutput($sformatf("stepUla%0d", i),   32'(tallyUla[i]),    32'd1);
      checkOutput($sformatf("stepRf%0d", i),    32'(tallyRf[i]),     32'd1);
      checkOutput($sformatf("stepPc%0d", i),    32'(tallyPc[i]),     32'd1);
      checkOutput($sformatf("stepCount%0d", i), 32'(obsCount[i]),    32'd1);
      checkOutput($sformatf("stepIdle%0d", i),  32'(obsState[i]),    32'd0);
    end

    // Continuous run, no register writes
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    applyReset();
    clearTally();
    runIn = 2'b11;
    repeat (41) tick();
    checkOutput("runCount0", 32'(obsCount[0]), 32'd10);
    checkOutput("runPc0",    32'(tallyPc[0]),  32'd10);
    checkOutput("runRf0",    32'(tallyRf[0]),  32'd0);
    checkOutput("runCount1", 32'(obsCount[1]), 32'd6);
    checkOutput("runPc1",    32'(tallyPc[1]),  32'd6);
    checkOutput("runRf1",    32'(tallyRf[1]),  32'd0);
    runIn = 2'b00;
    repeat (8) tick();

    // Halt on the third instruction while run stays high
    applyReset();
    clearTally();
    applyStimulus(2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    repeat (40) begin
      for (int i = 0; i < NI; i++)
        dhIn[i] = !mIdle[i] && !mHalt[i] && mPos[i] == 1 && mCount[i] == 2;
      tick();
    end
    dhIn = 2'b00;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("haltPc%0d", i),     32'(tallyPc[i]),   32'd2);
      checkOutput($sformatf("haltRf%0d", i),     32'(tallyRf[i]),   32'd2);
      checkOutput($sformatf("haltState%0d", i),  32'(obsState[i]),  32'd7);
      checkOutput($sformatf("haltFlag%0d", i),   32'(obsHalted[i]), 32'd1);
      checkOutput($sformatf("haltCount%0d", i),  32'(obsCount[i]),  32'd3);
    end
    clrIn = 2'b11;
    tick();
    clrIn = 2'b00;
    runIn = 2'b00;
    checkOutput("clrHalt0", 32'(obsState[0]), 32'd0);
    checkOutput("clrHalt1", 32'(obsState[1]), 32'd0);
    repeat (3) tick();

    // Reset during EXEC
    applyReset();
    applyStimulus(2'b00, 2'b11, 2'b00, 2'b11, 2'b00);
    tick();
    stepIn = 2'b00;
    repeat (2) tick();
    checkOutput("inExec0", 32'(obsState[0]), 32'd3);
    clearTally();
    applyReset();
    checkOutput("rstMid0", 32'(obsState[0]), 32'd0);
    repeat (6) tick();
    checkOutput("rstMidRf0", 32'(tallyRf[0]), 32'd0);
    checkOutput("rstMidPc0", 32'(tallyPc[0]), 32'd0);

    // Counter wrap through 256 retired instructions
    applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (1021) tick();
    checkOutput("wrapPre0", 32'(obsCount[0]), 32'd255);
    repeat (4) tick();
    checkOutput("wrapPost0", 32'(obsCount[0]), 32'd0);
    runIn = 2'b00;
    repeat (10) tick();

    // A step edge during EXEC is dropped
    applyReset();
    applyStimulus(2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    tick();
    stepIn = 2'b00;
    repeat (2) tick();
    stepIn = 2'b11;
    tick();
    stepIn = 2'b00;
    repeat (6) tick();
    checkOutput("dropCount0", 32'(obsCount[0]), 32'd1);
    checkOutput("dropCount1", 32'(obsCount[1]), 32'd1);

    // Randomized traffic with occasional resets
    repeat (800) begin
      for (int i = 0; i < NI; i++) begin
        if ($urandom_range(0, 19) == 0) runIn[i] = ~runIn[i];
        if ($urandom_range(0, 3) == 0)  stepIn[i] = ~stepIn[i];
        clrIn[i] = ($urandom_range(0, 7) == 0);
        drIn[i]  = 1'($urandom_range(0, 1));
        dhIn[i]  = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 199) == 0) applyReset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multicycle control sequencer for CPU v0.1. It steps the datapath through fetch, decode, execute and writeback for each instruction: the PC, the instruction memory, the control unit, the register file and the ULA. Instructions run either one at a time (single-step from a debounced key) or continuously. The block also exports its state and a retired-instruction count for the LCD/7-segment debug displays.

## Interface
Parameters:
- WAIT_CYCLES, default 0: idle cycles inserted between WB and the next FETCH in run mode (0..255).
- CNT_W, default 8: width of `instr_count`.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  level. While high, instructions execute back-to-back.
- `step`  in  1  level from a debounced key. Each rising edge while IDLE executes exactly one instruction.
- `clr_halt`  in  1  level. Leaves HALT for IDLE.
- `dec_reg_write`  in  1  control-unit decode: the instruction writes the register file.
- `dec_halt`  in  1  control-unit decode: the instruction is a halt.
- `ir_load`  out  1  instruction register captures instruction-memory data (ROM data is valid in FETCH).
- `ula_en`  out  1  ULA result register captures the result.
- `rf_we`  out  1  register-file write enable (`we3`).
- `pc_en`  out  1  PC advances by one.
- `busy`  out  1  high in FETCH, DECODE, EXEC, WB and WAIT.
- `halted`  out  1  high in HALT.
- `state`  out  3  current state encoding, for debug display.
- `instr_count`  out  CNT_W  retired-instruction counter.

## Operation
State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, WAIT=5, HALT=7. Code 6 is illegal and recovers to IDLE on the next clock.

Step edge detection:
- `step_q` is a registered copy of `step`.
- `step_rise = step & ~step_q`.
- `step_q` resets to 0.

Transitions:
- IDLE -> FETCH if `run` or `step_rise`; otherwise stay in IDLE.
- FETCH -> DECODE, unconditionally.
- DECODE -> EXEC. The block latches `dec_reg_write` into `rw_l` and `dec_halt` into `h_l` on this edge.
- EXEC -> WB.
- WB:
  - -> HALT if `h_l`.
  - else -> WAIT if `run` and WAIT_CYCLES > 0.
  - else -> FETCH if `run`.
  - else -> IDLE.
- WAIT: an internal counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - At 0: -> FETCH if `run`, else -> IDLE.
  - If `run` drops mid-WAIT: -> IDLE on the next edge.
- HALT -> IDLE when `clr_halt` is high. While halted, `run` and `step` are ignored.

Strobes are Moore outputs decoded from state only:
- `ir_load` = (state==FETCH).
- `ula_en` = (state==EXEC).
- `rf_we` = (state==WB) & `rw_l` & ~`h_l`.
- `pc_en` = (state==WB) & ~`h_l`. A halt instruction does not advance the PC and never writes a register.

Counter and priority rules:
- `instr_count` increments by 1 on every WB exit, including a halt instruction. It wraps from 2^CNT_W-1 to 0.
- `run` has priority over `step`.
- Step edges that arrive while `busy` or `halted` are dropped, not queued.
- `rst` mid-instruction:
  - state -> IDLE immediately (asynchronous).
  - All strobes go low; no partial writeback occurs.
  - `rw_l`, `h_l`, the WAIT counter and `instr_count` clear to 0.

## Timing
- Reset values: `state`=0, `busy`=0, `halted`=0, `ir_load`=`ula_en`=`rf_we`=`pc_en`=0, `instr_count`=0.
- Single step:
  - Edge k samples `step` high with `step_q` low.
  - FETCH occupies cycle k+1, DECODE k+2, EXEC k+3, WB k+4.
  - Back in IDLE at k+5.
- Run mode with WAIT_CYCLES=0: one instruction every 4 cycles, with no bubble between WB and FETCH.
- Run mode with WAIT_CYCLES=N: one instruction every 4+N cycles.
- Decode inputs must be stable by the end of DECODE. They are ignored in all other states.
- `pc_en` and `rf_we` are asserted in the same single cycle, so the register file writes the old-PC instruction result.
- `instr_count` updates on the edge ending WB, so it is visible in the following cycle.

## Test plan
- Reset check: assert `rst` for 3 cycles, then release. All outputs must be 0 and `state`=0. Hold `run`=0 and `step`=0 for 10 cycles; `state` must remain 0.
- Single step: pulse `step` high for 6 cycles with `dec_reg_write`=1.
  - Exactly one each of `ir_load`, `ula_en`, `rf_we` and `pc_en`, in consecutive FETCH/EXEC/WB cycles.
  - `instr_count` becomes 1; the block returns to IDLE. The held-high step must not retrigger.
- Run with WAIT_CYCLES=0: hold `run`=1 for 40 cycles with `dec_reg_write`=0.
  - `instr_count`=10 and `rf_we` is never asserted.
  - `pc_en` is high every 4th cycle.
  - Repeat with WAIT_CYCLES=3: `pc_en` every 7th cycle.
- Halt: `run`=1 with `dec_halt`=1 on the 3rd instruction.
  - `pc_en` pulses twice only; `state`=7 and `halted`=1 persist while `run` stays high.
  - `instr_count`=3.
  - `clr_halt`=1 for one cycle -> IDLE.
- Reset mid-instruction: assert `rst` during EXEC. `state`=0 immediately, and no `rf_we`/`pc_en` pulse follows.
- Wrap and priority:
  - Preload via 256 run instructions; `instr_count` goes 255 -> 0.
  - `step` edge during EXEC is dropped, so the count increases by 1, not 2.
